// File: rtl/nibble_entry_ctrl_if.sv
// Keypad-entry bus between the scanner/consumer side and nibble_entry_ctrl.
//   key_valid, key_code, clear, out_ready : towards the controller
//   word, word_valid, digit_count,
//   shift_en, timeout                     : from the controller
// master = keypad/consumer side, slave = controller.
interface nibble_entry_ctrl_if #(
    parameter int unsigned NIBBLES = 4
);
    logic                   key_valid;
    logic [3:0]             key_code;
    logic                   clear;
    logic                   out_ready;
    logic [4*NIBBLES-1:0]   word;
    logic                   word_valid;
    logic [2:0]             digit_count;
    logic                   shift_en;
    logic                   timeout;

    modport master (
        output key_valid, key_code, clear, out_ready,
        input  word, word_valid, digit_count, shift_en, timeout
    );

    modport slave (
        input  key_valid, key_code, clear, out_ready,
        output word, word_valid, digit_count, shift_en, timeout
    );
endinterface

// File: rtl/nibble_entry_ctrl.sv
// nibble_entry_ctrl: assembles NIBBLES key codes into one word and offers it
// downstream on a valid/ready handshake, then clears for the next entry.
// Ports:
//   clk    : system clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : nibble_entry_ctrl_if.slave (key_valid, key_code, clear,
//            out_ready in; word, word_valid, digit_count, shift_en, timeout out)
// Optional feature macro: ENTRY_TIMEOUT_EN -- discards a partial entry after
// TIMEOUT_CYCLES idle cycles; when undefined no counter exists, timeout = 0.
module nibble_entry_ctrl #(
    parameter int unsigned NIBBLES        = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1000
) (
    input  logic                clk,
    input  logic                rst_n,
    nibble_entry_ctrl_if.slave  bus
);
    localparam int unsigned W = 4 * NIBBLES;

    if (NIBBLES < 2 || NIBBLES > 7 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("nibble_entry_ctrl: unsupported NIBBLES/TIMEOUT_CYCLES");
    end

    typedef enum logic {COLLECT, HOLD} state_t;

    state_t         state_q, state_d;
    logic           key_d_q;
    logic [W-1:0]   word_q, word_d;
    logic [2:0]     cnt_q, cnt_d;
    logic           shift_en_q, shift_en_d;
    logic           timeout_q, timeout_d;
    logic           press;

    // key_d resets high so a key held through reset release is not a press.
    assign press = bus.key_valid & ~key_d_q;

`ifdef ENTRY_TIMEOUT_EN
    localparam int unsigned IW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT_CYCLES - 1);
    logic [IW-1:0]  idle_q, idle_d;
`endif

    always_comb begin
        state_d    = state_q;
        word_d     = word_q;
        cnt_d      = cnt_q;
        shift_en_d = 1'b0;
        timeout_d  = 1'b0;
`ifdef ENTRY_TIMEOUT_EN
        idle_d     = '0;
`endif
        if (bus.clear) begin
            state_d = COLLECT;
            word_d  = '0;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                COLLECT: begin
                    if (press) begin
                        word_d     = {word_q[W-5:0], bus.key_code};
                        cnt_d      = 3'(cnt_q + 3'd1);
                        shift_en_d = 1'b1;
                        if (cnt_q == 3'(NIBBLES - 1)) begin
                            state_d = HOLD;
                        end
                    end
`ifdef ENTRY_TIMEOUT_EN
                    // A press on the expiry cycle is taken by the branch above.
                    else if (cnt_q != '0) begin
                        if (idle_q == IDLE_LAST) begin
                            word_d    = '0;
                            cnt_d     = '0;
                            timeout_d = 1'b1;
                        end else begin
                            idle_d = IW'(idle_q + 1'b1);
                        end
                    end
`endif
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        state_d = COLLECT;
                        word_d  = '0;
                        cnt_d   = '0;
                    end
                end
                default: state_d = COLLECT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= COLLECT;
            key_d_q    <= 1'b1;
            word_q     <= '0;
            cnt_q      <= '0;
            shift_en_q <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            key_d_q    <= bus.key_valid;
            word_q     <= word_d;
            cnt_q      <= cnt_d;
            shift_en_q <= shift_en_d;
            timeout_q  <= timeout_d;
        end
    end

`ifdef ENTRY_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_q <= '0;
        end else begin
            idle_q <= idle_d;
        end
    end
`endif

    assign bus.word        = word_q;
    assign bus.word_valid  = (state_q == HOLD);
    assign bus.digit_count = cnt_q;
    assign bus.shift_en    = shift_en_q;
    assign bus.timeout     = timeout_q;

endmodule
